// File: rtl/word_request_encoder_if.sv
// word_request_encoder_if: word-request lines in, address/valid handshake and busy out
interface word_request_encoder_if;
  logic [7:0] word_request;
  logic       ready;
  logic [2:0] address;
  logic       valid;
  logic       busy;
  modport master (input word_request, ready, output address, valid, busy);
  modport slave  (output word_request, ready, input address, valid, busy);
endinterface

// File: rtl/word_request_encoder.sv
// word_request_encoder: round-robin 8-to-3 encoder of sticky word requests into a registered address/valid stream
module word_request_encoder (
  input  logic clk,
  input  logic reset,
  word_request_encoder_if.master bus
);
  logic [7:0] pending_q, pending_d;
  logic [2:0] last_q, last_d, addr_q, addr_d, sel;
  logic       valid_q, valid_d, load, found;
  always_comb begin
    load  = !valid_q || bus.ready;
    found = 1'b0;
    sel   = last_q;
    // descending scan so the nearest index after last wins
    for (int k = 8; k >= 1; k--) begin
      if (pending_q[last_q + 3'(k)]) begin
        found = 1'b1;
        sel   = last_q + 3'(k);
      end
    end
    pending_d = (pending_q & ~((load && found) ? (8'b1 << sel) : 8'h00)) | bus.word_request;
    valid_d   = load ? found : valid_q;
    addr_d    = (load && found) ? sel : addr_q;
    last_d    = (load && found) ? sel : last_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 8'h00;
      last_q    <= 3'd7;
      addr_q    <= 3'd0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
    end
  end
  assign bus.address = addr_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = valid_q | (|pending_q);
endmodule

// File: tb/tb_word_request_encoder.sv
// tb_word_request_encoder: directed tables, hand sequences and random traffic against a reference model
module tb_word_request_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  word_request_encoder_if bus ();
  word_request_encoder dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit [7:0] m_pend;
  int       m_last;
  bit       m_valid;
  int       m_addr;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       v;
    logic [2:0] a;
    logic       b;
  } vec_t;
  vec_t tv[21];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 8'h00; m_last = 7; m_valid = 1'b0; m_addr = 0;
  endtask

  task automatic model_edge(input bit [7:0] req, input bit rdy);
    bit [7:0] np;
    int sel;
    np  = m_pend | req;
    sel = -1;
    for (int k = 1; k <= 8; k++)
      if (sel < 0 && m_pend[(m_last + k) % 8]) sel = (m_last + k) % 8;
    if (!m_valid || rdy) begin
      if (sel >= 0) begin
        m_addr = sel; m_valid = 1'b1; m_last = sel;
        np = (m_pend & ~(8'h01 << sel)) | req;
      end else m_valid = 1'b0;
    end
    m_pend = np;
  endtask

  task automatic step(input logic [7:0] req, input logic rdy);
    @(negedge clk);
    bus.word_request = req;
    bus.ready = rdy;
    @(posedge clk);
    model_edge(req, rdy);
    #1;
    check("model_valid", int'(bus.valid), int'(m_valid));
    check("model_addr", int'(bus.address), m_addr);
    check("model_busy", int'(bus.busy), int'(m_valid || (m_pend != 0)));
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_valid", int'(bus.valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_addr", int'(bus.address), 0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.word_request = 8'h00;
    bus.ready = 1'b1;
    model_reset();
    tv[0]  = '{8'hFF, 1'b1, 1'b0, 3'd0, 1'b1};
    for (int i = 0; i < 8; i++) tv[1+i] = '{8'h00, 1'b1, 1'b1, 3'(i), 1'b1};
    tv[9]  = '{8'h00, 1'b1, 1'b0, 3'd7, 1'b0};
    tv[10] = '{8'h20, 1'b1, 1'b0, 3'd7, 1'b1};
    tv[11] = '{8'h00, 1'b1, 1'b1, 3'd5, 1'b1};
    tv[12] = '{8'h00, 1'b1, 1'b0, 3'd5, 1'b0};
    tv[13] = '{8'h0C, 1'b0, 1'b0, 3'd5, 1'b1};
    for (int i = 0; i < 5; i++) tv[14+i] = '{8'h00, 1'b0, 1'b1, 3'd2, 1'b1};
    tv[19] = '{8'h00, 1'b1, 1'b1, 3'd3, 1'b1};
    tv[20] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b0};
    #12 reset = 1'b0;
    check("reset_valid", int'(bus.valid), 0);
    check("reset_busy", int'(bus.busy), 0);

    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b1);
      check("idle_valid", int'(bus.valid), 0);
      check("idle_busy", int'(bus.busy), 0);
      check("idle_addr", int'(bus.address), 0);
    end

    // full sweep, single pulse, then backpressure on 0x0C
    foreach (tv[i]) begin
      step(tv[i].req, tv[i].rdy);
      check($sformatf("tv%0d_valid", i), int'(bus.valid), int'(tv[i].v));
      check($sformatf("tv%0d_addr", i), int'(bus.address), int'(tv[i].a));
      check($sformatf("tv%0d_busy", i), int'(bus.busy), int'(tv[i].b));
    end

    pulse_reset();
    step(8'h81, 1'b1);
    check("rr_first_valid", int'(bus.valid), 0);
    for (int i = 0; i < 8; i++) begin
      step(8'h81, 1'b1);
      check("rr_valid", int'(bus.valid), 1);
      check("rr_addr", int'(bus.address), (i % 2 == 0) ? 0 : 7);
    end

    pulse_reset();
    step(8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b1);
    check("mid_addr3", int'(bus.address), 3);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1);
      check("post_rst_valid", int'(bus.valid), 0);
    end
    step(8'h01, 1'b1);
    check("new_pulse_busy", int'(bus.busy), 1);
    step(8'h00, 1'b1);
    check("new_pulse_valid", int'(bus.valid), 1);
    check("new_pulse_addr", int'(bus.address), 0);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] r;
      r = 8'($urandom & $urandom & $urandom);
      step(r, 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
